// File: rtl/fetch_pc_unit.sv
// Instruction-fetch PC unit: one outstanding bus request, presents fetched instruction + PC same cycle as data_ok.
// Latency: 0 cycles from data_ok to out_valid; next request the cycle after. Backpressure: stall parks the entry in HOLD.
// Optional misaligned-PC trapping is enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_pc_unit #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        stall,
    output logic        out_valid,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_misalign
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [63:0] pc, pc_nxt;
    logic [63:0] pending_pc, pending_pc_nxt;
    logic [31:0] hold_instr, hold_instr_nxt;
    logic        hold_mis, hold_mis_nxt;

    logic        misaligned;
    logic        fetch_ok;
    logic [31:0] fetch_instr;
    logic        present_mis;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misaligned = (pc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // A misaligned PC never reaches the bus; it completes locally with a NOP.
    always_comb begin
        fetch_ok    = iresp_data_ok;
        fetch_instr = iresp_data;
        if (misaligned) begin
            fetch_ok    = 1'b1;
            fetch_instr = NOP_INSTR;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        pending_pc_nxt = pending_pc;
        hold_instr_nxt = hold_instr;
        hold_mis_nxt   = hold_mis;
        ireq_valid     = 1'b0;
        ireq_addr      = pc;
        out_valid      = 1'b0;
        out_instr      = 32'h0;
        present_mis    = 1'b0;

        case (state)
            REQ: begin
                ireq_valid = ~misaligned;
                out_instr  = fetch_instr;
                if (redirect_valid) begin
                    if (fetch_ok) begin
                        pc_nxt = redirect_pc;
                    end else begin
                        pending_pc_nxt = redirect_pc;
                        state_nxt      = FLUSH;
                    end
                end else if (fetch_ok) begin
                    out_valid   = 1'b1;
                    present_mis = misaligned;
                    if (stall) begin
                        hold_instr_nxt = fetch_instr;
                        hold_mis_nxt   = misaligned;
                        state_nxt      = HOLD;
                    end else begin
                        pc_nxt = pc + 64'd4;
                    end
                end
            end

            HOLD: begin
                out_instr = hold_instr;
                if (redirect_valid) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = REQ;
                end else begin
                    out_valid   = 1'b1;
                    present_mis = hold_mis;
                    if (!stall) begin
                        pc_nxt    = pc + 64'd4;
                        state_nxt = REQ;
                    end
                end
            end

            FLUSH: begin
                // The old request stays on the bus until it completes; its data is discarded.
                ireq_valid = 1'b1;
                if (redirect_valid) begin
                    pending_pc_nxt = redirect_pc;
                end
                if (iresp_data_ok) begin
                    pc_nxt    = redirect_valid ? redirect_pc : pending_pc;
                    state_nxt = REQ;
                end
            end

            default: begin
                state_nxt = REQ;
            end
        endcase

        if (reset) begin
            ireq_valid  = 1'b0;
            out_valid   = 1'b0;
            out_instr   = 32'h0;
            present_mis = 1'b0;
        end
    end

    assign out_pc       = pc;
    assign out_misalign = present_mis;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= REQ;
            pc         <= RESET_PC;
            pending_pc <= 64'h0;
            hold_instr <= 32'h0;
            hold_mis   <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            pending_pc <= pending_pc_nxt;
            hold_instr <= hold_instr_nxt;
            hold_mis   <= hold_mis_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized bench for fetch_pc_unit: random-latency memory, redirects, stalls and resets against a fetch-stream model.
module tb_fetch_pc_unit;

    localparam logic [63:0] RST_PC = 64'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        stall;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_misalign;

    always #5 clk = ~clk;

    fetch_pc_unit #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_misalign   (out_misalign)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1234_5678;
    endfunction

    // Fetch-stream model: where the program is, whether a fetched word is waiting
    // downstream, and whether the bus beat in flight belongs to an abandoned path.
    logic [63:0] m_pc;
    logic [63:0] m_target;
    bit          m_discard;
    bit          m_parked;
    logic [31:0] m_parked_instr;
    bit          m_parked_mis;

    // Memory: one request at a time with a random number of wait cycles.
    bit mem_busy;
    int mem_wait;

    int p_redir, p_stall, max_wait, p_rst, rst_left;

    task automatic model_reset();
        m_pc           = RST_PC;
        m_target       = 64'h0;
        m_discard      = 0;
        m_parked       = 0;
        m_parked_instr = 32'h0;
        m_parked_mis   = 0;
        mem_busy       = 0;
        mem_wait       = 0;
    endtask

    function automatic logic [63:0] pick_target();
        logic [63:0] t;
        int r;
        r = $urandom_range(0, 9);
        t = RST_PC + 64'($urandom_range(0, 1023));
        if (r == 0)      t = 64'hFFFF_FFFF_FFFF_FFF8;
        else if (r == 1) t = 64'hFFFF_FFFF_FFFF_FFFC;
        else if (r >= 3) t[1:0] = 2'b00;
        return t;
    endfunction

    task automatic step();
        logic        e_req, e_ov, e_mis, got, gmis, mis;
        logic [63:0] e_pc;
        logic [31:0] e_instr, ginstr;

        @(posedge clk);
        #1;
        if (rst_left > 0) begin
            reset = 1'b1;
            rst_left--;
        end else if ($urandom_range(0, 999) < p_rst) begin
            reset    = 1'b1;
            rst_left = $urandom_range(0, 2);
        end else begin
            reset = 1'b0;
        end
        redirect_valid = ($urandom_range(0, 99) < p_redir);
        redirect_pc    = pick_target();
        stall          = ($urandom_range(0, 99) < p_stall);

        if (reset) begin
            iresp_data_ok = 1'($urandom_range(0, 1));
            iresp_data    = $urandom;
        end else begin
            if (ireq_valid && !mem_busy) begin
                mem_busy = 1;
                mem_wait = $urandom_range(0, max_wait);
            end
            iresp_data_ok = ireq_valid && mem_busy && (mem_wait == 0);
            iresp_data    = iresp_data_ok ? mem_word(ireq_addr) : $urandom;
        end
        #1;

`ifdef FETCH_MISALIGN_CHECK_EN
        mis = (m_pc[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        got    = mis ? 1'b1 : iresp_data_ok;
        ginstr = mis ? NOP : mem_word(m_pc);
        gmis   = mis;

        e_pc    = m_pc;
        e_instr = 32'h0;
        e_mis   = 1'b0;
        if (reset) begin
            e_req = 1'b0;
            e_ov  = 1'b0;
        end else if (m_parked) begin
            e_req   = 1'b0;
            e_ov    = !redirect_valid;
            e_instr = m_parked_instr;
            e_mis   = e_ov && m_parked_mis;
        end else if (m_discard) begin
            e_req = 1'b1;
            e_ov  = 1'b0;
        end else begin
            e_req   = !mis;
            e_ov    = got && !redirect_valid;
            e_instr = ginstr;
            e_mis   = e_ov && gmis;
        end

        chk("ireq_valid", 64'(ireq_valid), 64'(e_req));
        if (e_req) chk("ireq_addr", ireq_addr, m_pc);
        chk("out_valid", 64'(out_valid), 64'(e_ov));
        chk("out_misalign", 64'(out_misalign), 64'(e_mis));
        if (e_ov || reset) begin
            chk("out_pc", out_pc, e_pc);
            chk("out_instr", 64'(out_instr), 64'(e_instr));
        end

        if (reset) begin
            model_reset();
        end else begin
            if (m_parked) begin
                if (redirect_valid) begin
                    m_pc     = redirect_pc;
                    m_parked = 0;
                end else if (!stall) begin
                    m_pc     = m_pc + 64'd4;
                    m_parked = 0;
                end
            end else if (m_discard) begin
                if (redirect_valid) m_target = redirect_pc;
                if (iresp_data_ok) begin
                    m_pc      = m_target;
                    m_discard = 0;
                end
            end else if (redirect_valid) begin
                if (got) begin
                    m_pc = redirect_pc;
                end else begin
                    m_discard = 1;
                    m_target  = redirect_pc;
                end
            end else if (got) begin
                if (stall) begin
                    m_parked       = 1;
                    m_parked_instr = ginstr;
                    m_parked_mis   = gmis;
                end else begin
                    m_pc = m_pc + 64'd4;
                end
            end
            if (iresp_data_ok) mem_busy = 0;
            else if (mem_busy && mem_wait > 0) mem_wait--;
        end
    endtask

    task automatic run(input int redir, input int stl, input int wt, input int rst, input int n);
        p_redir  = redir;
        p_stall  = stl;
        max_wait = wt;
        p_rst    = rst;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        stall          = 1'b0;
        iresp_data_ok  = 1'b0;
        iresp_data     = 32'h0;
        model_reset();
        @(posedge clk);
        rst_left = 2;
        run(0, 0, 0, 0, 8);
        run(0, 0, 3, 0, 40);
        run(0, 40, 2, 0, 60);
        run(20, 0, 3, 0, 200);
        run(25, 30, 3, 5, 3000);
        run(50, 50, 0, 5, 1000);
        run(10, 10, 1, 2, 1000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch front end: owns the program counter, issues one instruction-bus request at a time, and presents each returned instruction with its PC to the fetch/decode pipeline register. It sits directly upstream of that register: `out_*` feed it and `stall` comes back from it. It takes PC redirects from the branch/trap logic and keeps the bus request stable while a redirect is pending.

## Interface
- `RESET_PC`, default 64'h8000_0000, PC fetched first after reset.
- `clk` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `ireq_valid` out 1: instruction request valid.
- `ireq_addr` out 64: request address.
- `iresp_data_ok` in 1: response for the current request is valid this cycle.
- `iresp_data` in 32: instruction word, valid when `iresp_data_ok` = 1.
- `redirect_valid` in 1: redirect the PC; sampled every cycle.
- `redirect_pc` in 64: redirect target.
- `stall` in 1: the downstream register will not accept `out_*` this cycle.
- `out_valid` out 1: `out_pc` and `out_instr` hold a valid fetched instruction.
- `out_pc` out 64: PC of the presented instruction.
- `out_instr` out 32: presented instruction.
- `out_misalign` out 1: presented entry comes from a misaligned PC (see Configuration).

## Operation
- State registers: `pc` (64), `pending_pc` (64), `hold_instr` (32), and FSM state, one of REQ, HOLD or FLUSH.
- Reset values:
  - `pc` = RESET_PC, state = REQ, `pending_pc` = 0, `hold_instr` = 0.
  - While `reset` = 1: `ireq_valid` = 0, `out_valid` = 0, `out_misalign` = 0, `out_pc` = `pc`, `out_instr` = 0.
- Bus rule: once `ireq_valid` = 1, `ireq_valid` and `ireq_addr` stay constant until the cycle in which `iresp_data_ok` = 1. A request is never withdrawn.
- REQ: `ireq_valid` = 1, `ireq_addr` = `pc`.
  - Redirect with `data_ok`: drop the data, `out_valid` = 0, `pc` <= `redirect_pc`, stay in REQ.
  - Redirect without `data_ok`: `pending_pc` <= `redirect_pc`, go to FLUSH.
  - `data_ok` without redirect: `out_valid` = 1, `out_pc` = `pc`, `out_instr` = `iresp_data`, all combinational in the same cycle.
    - If `stall` = 0: `pc` <= `pc` + 4, stay in REQ.
    - If `stall` = 1: `hold_instr` <= `iresp_data`, go to HOLD.
  - No `data_ok`: `out_valid` = 0.
- HOLD: `ireq_valid` = 0. `out_valid` = 1, `out_pc` = `pc`, `out_instr` = `hold_instr`.
  - Redirect: `out_valid` = 0, `pc` <= `redirect_pc`, go to REQ.
  - Else if `stall` = 0: the instruction is consumed, `pc` <= `pc` + 4, go to REQ.
- FLUSH: `ireq_valid` = 1, `ireq_addr` = `pc` (the old PC), `out_valid` = 0.
  - Redirect: `pending_pc` <= `redirect_pc`; the last redirect wins.
  - On `data_ok`: drop the data, `pc` <= the newest target (`redirect_pc` if a redirect arrives in the same cycle, else `pending_pc`), go to REQ.
- Redirect always takes priority over `data_ok` and `stall`.
- PC arithmetic is 64-bit modulo 2^64: 64'hFFFF_FFFF_FFFF_FFFC + 4 = 0.
- `redirect_valid` during reset is ignored.
- Reset asserted mid-request returns to the reset state. Any response arriving during or after reset for the abandoned request is ignored; the memory side resets on the same `reset`.

## Timing
- Zero-wait memory (`data_ok` in the request cycle) gives one instruction per cycle, with `out_valid` in the same cycle as the request.
- With N wait cycles: `out_valid` rises in the `data_ok` cycle, and the next request starts the cycle after.
- Redirect to first request at the new target:
  - Next cycle from REQ with `data_ok`, or from HOLD.
  - From REQ without `data_ok`: one cycle after the old request's `data_ok`.
- `ireq_addr` and `out_pc` change only on clock edges. `out_valid` and `out_instr` may change combinationally with `iresp_*` in REQ.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - In REQ with `pc[1:0]` != 0: `ireq_valid` = 0.
  - The entry is presented as if `data_ok` = 1, with `out_instr` = 32'h0000_0013 (NOP) and `out_misalign` = 1.
  - Stall, HOLD and redirect rules apply unchanged. The PC advances by 4; the trap logic is responsible for redirecting.
  - `out_misalign` = 0 for aligned entries.
- `FETCH_MISALIGN_CHECK_EN` undefined: `out_misalign` is tied to 0, and misaligned PCs are issued to the bus unchanged.

## Test plan
- Reset release, zero-wait memory, `stall` = 0, 4 cycles: `ireq_addr` = 8000_0000, …_0004, …_0008, …_000C; `out_valid` = 1 every cycle, with `out_pc` matching `ireq_addr`.
- 3-cycle memory latency: `ireq_valid` and `addr` are held stable for 3 cycles; `out_valid` pulses 1 cycle per `data_ok`, `out_instr` = `iresp_data`.
- `stall` = 1 for 2 cycles at the `data_ok` of 8000_0004: `ireq_valid` = 0, `out_pc` = 8000_0004 held with the same `out_instr`; the next request is 8000_0008 the cycle after `stall` drops.
- Redirect to 8000_0100 one cycle before the `data_ok` of 8000_0008 (2-wait memory): addr 8000_0008 is held until `data_ok`, its data is dropped (`out_valid` = 0), and the next request is 8000_0100.
- Two redirects (…_0200 then …_0300) during FLUSH, plus redirect with `data_ok` same cycle: the next address is …_0300, and no `out_valid` is seen for dropped data.
- With `FETCH_MISALIGN_CHECK_EN`, redirect to 8000_0102: no bus request; `out_valid` = 1, `out_misalign` = 1, `out_instr` = 0000_0013; the next PC is 8000_0106.
